// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count and error pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Flags decode the registered count only, so no input reaches them combinationally.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // A read frees a slot, so a full FIFO can still take a write in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented continuously; rd_en only acknowledges it.
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, thresholds 14/2).
// Follows the FWFT read timing when SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one word and check it; leaves rd_en high so callers may pop back-to-back.
  task automatic pop(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick();
`else
    rd_en = 1'b1;
    tick();
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_data", 32'(rd_data), 32'd0);
`endif

    // 1: fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
      chk("fill_ovf", 32'(overflow), 32'd0);
    end

    // 2: write while full is rejected
    wr_data = 8'hAA;
    tick();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    wr_en = 1'b0;
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_count2", 32'(count), 32'd16);

    // 3: drain, then one rejected read
    for (int i = 0; i < 16; i++) pop(8'(i));
    rd_en = 1'b0;
    tick();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    rd_en = 1'b1;
    tick();
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    tick();
    chk("unf_clear", 32'(underflow), 32'd0);

    // 4: 20 writes interleaved with 20 reads, pointers wrap
    wr_en = 1'b1; wr_data = 8'h80;
    tick();
    for (int k = 1; k < 20; k++) begin
      wr_data = 8'(8'h80 + k);
      pop(8'(8'h80 + k - 1));
      chk("wrap_count", 32'(count), 32'd1);
    end
    wr_en = 1'b0;
    pop(8'h93);
    rd_en = 1'b0;
    chk("wrap_end_count", 32'(count), 32'd0);

    // 5a: simultaneous write+read while full
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    chk("full_before", 32'(full), 32'd1);
    wr_data = 8'h55;
    pop(8'h10);
    wr_en = 1'b0;
    chk("wr_rd_full_count", 32'(count), 32'd16);
    chk("wr_rd_full_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) pop(8'(8'h10 + i));
    pop(8'h55);
    rd_en = 1'b0;
    chk("after_55_count", 32'(count), 32'd0);

    // 5b: simultaneous write+read while empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h66;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_rd_empty_unf", 32'(underflow), 32'd1);
    chk("wr_rd_empty_count", 32'(count), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("wr_rd_empty_valid", 32'(rd_valid), 32'd0);
`endif
    pop(8'h66);
    rd_en = 1'b0;
    tick();
    chk("after_66_empty", 32'(empty), 32'd1);

    // 6: reset mid-operation with a concurrent write
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE0 + i);
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1; wr_data = 8'h99;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("midrst_data", 32'(rd_data), 32'd0);
`endif
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", 32'(rd_data), 32'h3C);
    chk("fwft_valid", 32'(rd_valid), 32'd1);
`else
    chk("std_no_valid", 32'(rd_valid), 32'd0);
`endif
    pop(8'h3C);
    rd_en = 1'b0;
    tick();
    chk("final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
